// File: rtl/mult_bus_if.sv
// Shared bus between the multiply driver and the external multiplier.
// The master drives control and load data; the slave returns status and read data.
interface mult_bus_if #(
  parameter int n = 8
);
  logic [1:0]   func;
  logic         oe;
  logic         start;
  logic         ready;
  logic         data_drive;
  logic [n-1:0] data_out;
  logic [n-1:0] data_in;

  modport master (
    output func, oe, start, data_drive, data_out,
    input  ready, data_in
  );

  modport slave (
    input  func, oe, start, data_drive, data_out,
    output ready, data_in
  );
endinterface

// File: rtl/mult_bus_driver.sv
// Sequences a multiply on a shared-bus multiplier: load both operands,
// push start, wait for completion and read the product back in two halves.
module mult_bus_driver #(
  parameter int n       = 8,
  parameter int HOLD    = 50000,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1000000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [2*n-1:0] product,
  mult_bus_if.master     bus
);

  localparam int MAXC = (HOLD > TIMEOUT) ? HOLD : TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] C_SET  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] C_HOLD = CW'(HOLD - 1);
  localparam logic [CW-1:0] C_TO   = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD_M, LOAD_Q, GAP, START,
    WAIT_BUSY, WAIT_DONE, READ_LO, READ_HI, FINISH
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [n-1:0]   r_a;
  logic [n-1:0]   r_b;
  logic [n-1:0]   r_lo;
  logic [2*n-1:0] r_prod;
  logic [1:0]     r_func;
  logic           r_oe;
  logic           r_start;
  logic           r_drive;
  logic           r_busy;
  logic           r_done;
  logic           r_error;

  logic           w_set_end;
  logic           w_hold_end;
  logic           w_to_end;
  logic [n-1:0]   w_dout;

  assign w_set_end  = (r_cnt == C_SET);
  assign w_hold_end = (r_cnt == C_HOLD);
  assign w_to_end   = (r_cnt == C_TO);
  assign w_dout     = (r_func == 2'b01) ? r_b : r_a;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_lo    <= '0;
      r_prod  <= '0;
      r_func  <= 2'b10;
      r_oe    <= 1'b0;
      r_start <= 1'b0;
      r_drive <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      // saturating advance; every transition below restarts it at zero
      r_cnt   <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (req) begin
            r_a     <= a;
            r_b     <= b;
            r_busy  <= 1'b1;
            r_func  <= 2'b00;
            r_drive <= 1'b1;
            r_state <= LOAD_M;
          end
        end
        LOAD_M: if (w_set_end) begin
          r_cnt   <= '0;
          r_func  <= 2'b01;
          r_state <= LOAD_Q;
        end
        LOAD_Q: if (w_set_end) begin
          r_cnt   <= '0;
          r_func  <= 2'b10;
          r_drive <= 1'b0;
          r_state <= GAP;
        end
        GAP: begin
          r_cnt   <= '0;
          r_start <= 1'b1;
          r_state <= START;
        end
        START: if (w_hold_end) begin
          r_cnt   <= '0;
          r_start <= 1'b0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (!bus.ready || w_to_end) begin
          r_cnt   <= '0;
          r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.ready) begin
            r_cnt   <= '0;
            r_oe    <= 1'b1;
            r_state <= READ_LO;
          end else if (w_to_end) begin
            r_cnt   <= '0;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        READ_LO: if (w_set_end) begin
          r_cnt   <= '0;
          r_lo    <= bus.data_in;
          r_func  <= 2'b11;
          r_state <= READ_HI;
        end
        // product updates together with done so it never shows a half result
        READ_HI: if (w_set_end) begin
          r_cnt   <= '0;
          r_prod  <= {bus.data_in, r_lo};
          r_oe    <= 1'b0;
          r_func  <= 2'b10;
          r_done  <= 1'b1;
          r_state <= FINISH;
        end
        FINISH: begin
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign product        = r_prod;
  assign bus.func       = r_func;
  assign bus.oe         = r_oe;
  assign bus.start      = r_start;
  assign bus.data_drive = r_drive;
  assign bus.data_out   = w_dout;

endmodule

// File: tb/tb_mult_bus_driver.sv
// Bench for mult_bus_driver with a behavioural shared-bus multiplier
// and a done/error scoreboard.
module tb_mult_bus_driver;

  localparam int N      = 8;
  localparam int HOLD   = 4;
  localparam int SETTLE = 2;
  localparam int TO     = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req   = 1'b0;
  logic [7:0]  a     = '0;
  logic [7:0]  b     = '0;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] product;

  mult_bus_if #(.n(N)) bus ();

  mult_bus_driver #(
    .n(N), .HOLD(HOLD), .SETTLE(SETTLE), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .req(req),
    .a(a), .b(b), .busy(busy), .done(done),
    .error(error), .product(product), .bus(bus)
  );

  always #5 clock = ~clock;

  // 0: normal, 1: ready never returns, 2: ready never drops
  int          mode = 0;
  int          cd   = 0;
  logic        m_ready = 1'b1;
  logic [7:0]  m_reg = '0;
  logic [7:0]  q_reg = '0;
  logic [15:0] m_p;

  assign m_p = 16'(m_reg) * 16'(q_reg);
  assign bus.ready = m_ready;
  assign bus.data_in = bus.data_drive ? bus.data_out :
                       bus.oe ? ((bus.func == 2'b11) ? m_p[15:8] : m_p[7:0]) :
                       8'h00;

  always @(posedge clock) begin
    if (bus.func == 2'b00 && bus.data_drive) m_reg <= bus.data_in;
    if (bus.func == 2'b01 && bus.data_drive) q_reg <= bus.data_in;
    if (mode == 2) m_ready <= 1'b1;
    else if (bus.start) begin
      m_ready <= 1'b0;
      cd <= 5;
    end else if (mode == 0) begin
      if (cd > 1) cd <= cd - 1;
      else begin
        cd <= 0;
        m_ready <= 1'b1;
      end
    end
  end

  typedef struct packed {
    logic        err;
    logic [15:0] p;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ovl   = 0;
  int   dex   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // trace of func changes and start-high cycles for one operation
  bit         trace_on = 0;
  logic [1:0] last_func;
  logic [1:0] ftr[$];
  int         st_cnt = 0;

  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (trace_on) begin
      if (bus.func != last_func) begin
        ftr.push_back(bus.func);
        last_func = bus.func;
      end
      if (bus.start) st_cnt++;
    end
    if (!reset) begin
      if (bus.data_drive && bus.oe) ovl++;
      if (done && error) dex++;
      if (done || error) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got done=%0b error=%0b want none", done, error);
        end else begin
          e = sbq.pop_front();
          chk("sb_kind", {31'b0, error}, {31'b0, e.err});
          chk("sb_product", {16'b0, product}, {16'b0, e.p});
        end
      end
    end
  end

  task automatic issue(logic [7:0] ia, logic [7:0] ib, logic ee,
                       logic [15:0] ep, bit push);
    @(negedge clock);
    a = ia;
    b = ib;
    req = 1'b1;
    if (push) sbq.push_back('{err: ee, p: ep});
    @(negedge clock);
    req = 1'b0;
  endtask

  task automatic wait_end(string nm);
    int n = 0;
    while (!(done || error) && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!(done || error)) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done/error want one within 300 cycles", nm);
    end
    @(negedge clock);
  endtask

  task automatic wait_start_fall(output int at);
    logic p = 1'b0;
    int   n = 0;
    at = -1;
    while (n < 300) begin
      @(negedge clock);
      n++;
      if (p && !bus.start) begin
        at = cyc;
        break;
      end
      p = bus.start;
    end
    if (at < 0) begin
      total++;
      bad++;
      $display("FAIL start_fall_timeout: got none want falling start");
    end
  endtask

  logic [1:0]  exp_f[6] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
  logic [7:0]  va[4] = '{8'h03, 8'h10, 8'h00, 8'h80};
  logic [7:0]  vb[4] = '{8'h05, 8'h10, 8'hA5, 8'h02};
  logic [15:0] vp[4] = '{16'h000F, 16'h0100, 16'h0000, 16'h0100};

  initial begin
    int t0;
    int t1;
    int n;
    int rises;
    int dn;
    int tf;
    logic pb;

    repeat (3) @(negedge clock);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_error", {31'b0, error}, 0);
    chk("rst_start", {31'b0, bus.start}, 0);
    chk("rst_oe", {31'b0, bus.oe}, 0);
    chk("rst_drive", {31'b0, bus.data_drive}, 0);
    chk("rst_func", {30'b0, bus.func}, 32'h2);
    chk("rst_product", {16'b0, product}, 0);
    reset = 1'b0;

    // 0x0C * 0x0D with func sequence capture
    last_func = bus.func;
    ftr.push_back(bus.func);
    trace_on = 1;
    issue(8'h0C, 8'h0D, 1'b0, 16'h009C, 1);
    wait_end("op_0c0d");
    trace_on = 0;
    chk("func_seq_len", ftr.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("func_seq_%0d", i), {30'b0, ftr[i]}, {30'b0, exp_f[i]});
    chk("start_hold", st_cnt, HOLD);

    issue(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1);
    wait_end("op_ffff");
    chk("hi_byte", {24'b0, product[15:8]}, 32'hFE);

    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], 1'b0, vp[i], 1);
      wait_end("op_vec");
    end

    // ready never returns: WAIT_BUSY lasts one cycle, then TO cycles
    mode = 1;
    issue(8'h22, 8'h33, 1'b1, 16'h0100, 1);
    wait_start_fall(t0);
    n = 0;
    while (!error && n < 100) begin
      @(negedge clock);
      n++;
    end
    t1 = cyc;
    chk("err_seen", {31'b0, error}, 1);
    chk("err_latency", t1 - t0, 1 + TO);
    chk("err_busy", {31'b0, busy}, 0);
    @(negedge clock);
    chk("err_pulse", {31'b0, error}, 0);
    mode = 0;
    repeat (10) @(negedge clock);

    // ready never drops: WAIT_BUSY times out, then reads at once
    mode = 2;
    issue(8'h07, 8'h06, 1'b0, 16'h002A, 1);
    wait_start_fall(t0);
    n = 0;
    while (!bus.oe && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("wb_timeout", cyc - t0, 1 + TO);
    wait_end("op_nodrop");
    mode = 0;
    repeat (5) @(negedge clock);

    // reset on the 3rd START cycle
    issue(8'h05, 8'h05, 1'b0, 16'h0019, 0);
    n = 0;
    t1 = 0;
    while (t1 < 3 && n < 100) begin
      if (bus.start) t1++;
      if (t1 < 3) begin
        @(negedge clock);
        n++;
      end
    end
    chk("start_cycles_seen", t1, 3);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_start", {31'b0, bus.start}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_drive", {31'b0, bus.data_drive}, 0);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    issue(8'h09, 8'h0B, 1'b0, 16'h0063, 1);
    wait_end("op_after_rst");

    // req held high: three back-to-back ops, one idle cycle between
    repeat (3) sbq.push_back('{err: 1'b0, p: 16'h003F});
    @(negedge clock);
    a = 8'h07;
    b = 8'h09;
    req = 1'b1;
    pb = busy;
    rises = 0;
    dn = 0;
    tf = 0;
    n = 0;
    while (dn < 3 && n < 400) begin
      @(negedge clock);
      n++;
      if (pb && !busy) tf = cyc;
      if (!pb && busy) begin
        rises++;
        if (rises > 1) chk("b2b_gap", cyc - tf, 1);
      end
      pb = busy;
      if (done) dn++;
    end
    req = 1'b0;
    chk("b2b_done", dn, 3);
    chk("b2b_accepts", rises, 3);
    repeat (4) @(negedge clock);
    chk("b2b_stop", {31'b0, busy}, 0);

    chk("oe_drive_overlap", ovl, 0);
    chk("done_err_excl", dex, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
